// File: rtl/memwb_stage_reg_pkg.sv
// Shared constants for the MEM/WB stage: writeback source selects and
// RV32 load funct3 encodings.
package memwb_stage_reg_pkg;

  // Writeback source select encodings
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // RV32 load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/memwb_stage_reg_load_extend.sv
// Combinational RV32 load formatter: picks the addressed byte/half lane out
// of an aligned memory word and sign- or zero-extends it to XLEN.
module load_extend
  import memwb_stage_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane extraction and extension; unknown funct3 passes the whole word
  always_comb begin
    byte_lane = raw_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_lane = raw_i[7:0];
      2'd1:    byte_lane = raw_i[15:8];
      2'd2:    byte_lane = raw_i[23:16];
      default: byte_lane = raw_i[31:24];
    endcase
    // Halves only look at the upper offset bit; bit 0 is ignored
    half_lane = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    data_o    = raw_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_lane};
      F3_LW:   data_o = raw_i;
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/memwb_stage_reg.sv
// MEM/WB pipeline register: formats load data, selects the writeback source
// and registers the result for the register-file write port and WB forwarding.
//
// Control per rising edge, highest priority first:
//   rst_n (active-high despite its name) -> bubble (all outputs zero)
//   flush_i                              -> bubble, even if stall_i is set
//   stall_i                              -> hold every output
//   otherwise                            -> capture the MEM-stage instruction
// All outputs come straight from flops; no input reaches an output
// combinationally.
module memwb_stage_reg
  import memwb_stage_reg_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [XLEN-1:0]   wdata_o
);

  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   wb_data;

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]   wdata_q,    wdata_d;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3_i  (funct3_i),
    .addr_lo_i (addr_lo_i),
    .raw_i     (mem_rdata_i),
    .data_o    (load_data)
  );

  // Writeback source mux, all four encodings decoded
  always_comb begin
    wb_data = alu_result_i;
    case (wb_sel_i)
      WB_ALU:  wb_data = alu_result_i;
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4_i;
      WB_IMM:  wb_data = imm_i;
      default: wb_data = alu_result_i;
    endcase
  end

  // Next-state: flush > stall > load; writes to x0 and invalid slots never enable
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      wdata_d    = '0;
    end else if (!stall_i) begin
      valid_d    = valid_i;
      regwrite_d = RegWrite_i & valid_i & (rd_i != '0);
      rd_d       = rd_i;
      wdata_d    = wb_data;
    end
  end

  // Stage register with synchronous reset to a bubble
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign valid_o    = valid_q;
  assign RegWrite_o = regwrite_q;
  assign rd_o       = rd_q;
  assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_memwb_stage_reg.sv
// Bench for memwb_stage_reg: directed scenarios followed by random traffic,
// checked against a behavioural model of the writeback stage.
module tb_memwb_stage_reg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int W      = 2 + REG_AW + XLEN;

  logic              clk;
  logic              rst_n;
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic              RegWrite_i;
  logic [1:0]        wb_sel_i;
  logic [2:0]        funct3_i;
  logic [1:0]        addr_lo_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic [XLEN-1:0]   alu_result_i;
  logic [XLEN-1:0]   pc_plus4_i;
  logic [XLEN-1:0]   imm_i;
  logic [REG_AW-1:0] rd_i;
  logic              valid_o;
  logic              RegWrite_o;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {valid, RegWrite, rd, wdata} expected after each edge
  logic [W-1:0] exp_q[$];

  // Model state: what the WB stage should currently be presenting
  logic              m_valid;
  logic              m_rw;
  logic [REG_AW-1:0] m_rd;
  logic [XLEN-1:0]   m_wdata;

  memwb_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .RegWrite_i   (RegWrite_i),
    .wb_sel_i     (wb_sel_i),
    .funct3_i     (funct3_i),
    .addr_lo_i    (addr_lo_i),
    .mem_rdata_i  (mem_rdata_i),
    .alu_result_i (alu_result_i),
    .pc_plus4_i   (pc_plus4_i),
    .imm_i        (imm_i),
    .rd_i         (rd_i),
    .valid_o      (valid_o),
    .RegWrite_o   (RegWrite_o),
    .rd_o         (rd_o),
    .wdata_o      (wdata_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference load formatting using shifts and masks
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'h0000_00FF;
    h = (w >> (16 * (int'(off) / 2))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Advance the model by one edge using the currently driven inputs
  task automatic model_step();
    logic [31:0] src;
    if (rst_n || flush_i) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_wdata = '0;
    end else if (!stall_i) begin
      if (wb_sel_i == 2'd0)      src = alu_result_i;
      else if (wb_sel_i == 2'd1) src = ref_load(funct3_i, addr_lo_i, mem_rdata_i);
      else if (wb_sel_i == 2'd2) src = pc_plus4_i;
      else                       src = imm_i;
      m_valid = valid_i;
      m_rw    = valid_i && RegWrite_i && (rd_i != 0);
      m_rd    = rd_i;
      m_wdata = src;
    end
    exp_q.push_back({m_valid, m_rw, m_rd, m_wdata});
  endtask

  // Driver: set the MEM-stage instruction fields
  task automatic drive_instr(input logic v, input logic rw, input logic [4:0] rd,
                             input logic [1:0] sel, input logic [2:0] f3,
                             input logic [1:0] off, input logic [31:0] rdata,
                             input logic [31:0] alu, input logic [31:0] pc4,
                             input logic [31:0] imm);
    valid_i = v; RegWrite_i = rw; rd_i = rd; wb_sel_i = sel; funct3_i = f3;
    addr_lo_i = off; mem_rdata_i = rdata; alu_result_i = alu;
    pc_plus4_i = pc4; imm_i = imm;
  endtask

  task automatic drive_ctrl(input logic r, input logic f, input logic s);
    rst_n = r; flush_i = f; stall_i = s;
  endtask

  // One clock: predict, take the edge, compare the scoreboard entry
  task automatic cycle(input string tag);
    logic [W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_valid"}, 64'(valid_o),    64'(e[W-1]));
      check_val({tag, "_rw"},    64'(RegWrite_o), 64'(e[W-2]));
      check_val({tag, "_rd"},    64'(rd_o),       64'(e[XLEN +: REG_AW]));
      check_val({tag, "_wdata"}, 64'(wdata_o),    64'(e[XLEN-1:0]));
    end
  endtask

  localparam logic [31:0] RDATA = 32'h80F0_7F81;

  initial begin
    m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_wdata = '0;
    drive_ctrl(1'b1, 1'b0, 1'b0);
    drive_instr(1'b1, 1'b1, 5'd9, 2'd0, 3'd2, 2'd0, 32'h1111_1111,
                32'h2222_2222, 32'h3333_3333, 32'h4444_4444);

    // Reset held for two edges
    cycle("reset0");
    cycle("reset1");
    check_val("reset_wdata_zero", 64'(wdata_o), 64'd0);

    // Reset then ALU load end to end
    drive_ctrl(1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 1'b1, 5'd5, 2'b00, 3'd2, 2'd0, RDATA, 32'h0000_1234, 32'd0, 32'd0);
    cycle("alu");
    check_val("alu_const", 64'(wdata_o), 64'h0000_1234);

    // Load extension cases
    drive_instr(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 2'd0, RDATA, 32'd0, 32'd0, 32'd0);
    cycle("lb0");  check_val("lb0_const", 64'(wdata_o), 64'hFFFF_FF81);
    drive_instr(1'b1, 1'b1, 5'd6, 2'b01, 3'b100, 2'd3, RDATA, 32'd0, 32'd0, 32'd0);
    cycle("lbu3"); check_val("lbu3_const", 64'(wdata_o), 64'h0000_0080);
    drive_instr(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 2'd2, RDATA, 32'd0, 32'd0, 32'd0);
    cycle("lh2");  check_val("lh2_const", 64'(wdata_o), 64'hFFFF_80F0);
    drive_instr(1'b1, 1'b1, 5'd6, 2'b01, 3'b101, 2'd0, RDATA, 32'd0, 32'd0, 32'd0);
    cycle("lhu0"); check_val("lhu0_const", 64'(wdata_o), 64'h0000_7F81);
    drive_instr(1'b1, 1'b1, 5'd6, 2'b01, 3'b010, 2'd1, RDATA, 32'd0, 32'd0, 32'd0);
    cycle("lw");   check_val("lw_const", 64'(wdata_o), 64'h80F0_7F81);

    // x0 suppression
    drive_instr(1'b1, 1'b1, 5'd0, 2'b00, 3'd2, 2'd0, RDATA, 32'hABCD, 32'd0, 32'd0);
    cycle("x0");   check_val("x0_rw_const", 64'(RegWrite_o), 64'd0);

    // Stall hold then flush priority
    drive_instr(1'b1, 1'b1, 5'd7, 2'b00, 3'd2, 2'd0, RDATA, 32'hDEAD_BEEF, 32'd0, 32'd0);
    cycle("pre_stall");
    drive_ctrl(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_instr(1'b1, 1'b1, 5'(10 + i), 2'(i), 3'd0, 2'(i), 32'h1357_9BDF + i,
                  32'h100 + i, 32'h200 + i, 32'h300 + i);
      cycle("stall");
    end
    check_val("stall_wdata_const", 64'(wdata_o), 64'hDEAD_BEEF);
    check_val("stall_rd_const",    64'(rd_o),    64'd7);
    drive_ctrl(1'b0, 1'b1, 1'b1);
    cycle("flush_stall");
    check_val("flush_valid_const", 64'(valid_o), 64'd0);

    // Source select
    drive_ctrl(1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 1'b1, 5'd1, 2'b10, 3'd2, 2'd0, RDATA, 32'd0, 32'h0000_0104, 32'h1234_5000);
    cycle("pc4");  check_val("pc4_const", 64'(wdata_o), 64'h0000_0104);
    drive_instr(1'b1, 1'b1, 5'd1, 2'b11, 3'd2, 2'd0, RDATA, 32'd0, 32'h0000_0104, 32'h1234_5000);
    cycle("imm");  check_val("imm_const", 64'(wdata_o), 64'h1234_5000);

    // Invalid slot: no write enable, fields still captured
    drive_instr(1'b0, 1'b1, 5'd12, 2'b00, 3'd2, 2'd0, RDATA, 32'h55AA, 32'd0, 32'd0);
    cycle("invalid");

    // Mid-operation reset drops the second write
    drive_instr(1'b1, 1'b1, 5'd3, 2'b00, 3'd2, 2'd0, RDATA, 32'h33, 32'd0, 32'd0);
    cycle("mid_rd3");
    drive_ctrl(1'b1, 1'b0, 1'b0);
    drive_instr(1'b1, 1'b1, 5'd4, 2'b00, 3'd2, 2'd0, RDATA, 32'h44, 32'd0, 32'd0);
    cycle("mid_rst");
    check_val("mid_rst_rd_const", 64'(rd_o), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_ctrl(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) == 0));
      drive_instr(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 31)),
                  2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom,
                  $urandom, $urandom);
      cycle("rand");
    end

    // Final report
    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memwb_stage_reg.md
Name: memwb_stage_reg

Overview:
- Parametrised, clocked MEM/WB pipeline register for the 5-stage core. It replaces the combinational MEM/WB writeback select.
- Captures memory-stage results on `clk` and supports stall (hold) and flush (bubble).
- Performs RV32 load alignment and sign/zero extension, and selects among four writeback sources.
- Its outputs drive the register-file write port and the WB→EX forwarding path.

Parameters:
- XLEN, 32, datapath width in bits; must be 32 for load extension semantics.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- stall_i  in  1  hold current contents.
- flush_i  in  1  replace contents with a bubble.
- valid_i  in  1  MEM-stage instruction is valid.
- RegWrite_i  in  1  MEM-stage instruction writes a register.
- wb_sel_i  in  2  writeback source select:
  - 00 = ALU
  - 01 = load data
  - 10 = PC+4
  - 11 = immediate (LUI)
- funct3_i  in  3  load size/sign (RV32 encoding).
- addr_lo_i  in  2  byte offset, i.e. ALU result bits [1:0] of the load address.
- mem_rdata_i  in  XLEN  raw aligned word from data memory.
- alu_result_i  in  XLEN  ALU result.
- pc_plus4_i  in  XLEN  link value.
- imm_i  in  XLEN  U-type immediate.
- rd_i  in  REG_AW  destination register.
- valid_o  out  1  WB-stage instruction valid.
- RegWrite_o  out  1  register-file write enable.
- rd_o  out  REG_AW  register-file write index.
- wdata_o  out  XLEN  register-file write data.

Behaviour:
- Latency: exactly 1 cycle; inputs sampled at edge N appear on outputs after edge N.
- Per-edge priority: rst_n > flush_i > stall_i > load.
- Reset (rst_n=1 at edge):
  - valid_o=0, RegWrite_o=0, rd_o=0, wdata_o=0.
  - A mid-operation reset discards any in-flight instruction.
- Flush:
  - Loads a bubble with the same values as reset.
  - flush_i and stall_i together: flush wins.
- Stall: all outputs hold their previous values.
- Load (no reset/flush/stall):
  - valid_o ← valid_i.
  - rd_o ← rd_i.
  - RegWrite_o ← RegWrite_i & valid_i & (rd_i != 0); writes to x0 are never asserted.
  - wdata_o ← selected source.
- Invalid instruction (valid_i=0 on load): RegWrite_o=0. rd_o and wdata_o are still captured (don't-care for the register file).
- Load data formatting (used when wb_sel_i=01), combinational before the register:
  - Byte lane = mem_rdata_i[8*addr_lo_i +: 8].
  - Half lane = mem_rdata_i[16*addr_lo_i[1] +: 16]; addr_lo_i[0] is ignored for halves.
  - funct3 000 LB: sign-extend byte.
  - funct3 100 LBU: zero-extend byte.
  - funct3 001 LH: sign-extend half.
  - funct3 101 LHU: zero-extend half.
  - funct3 010 LW: full word; addr_lo_i ignored.
  - Any other funct3: full word.
- wb_sel_i is fully decoded and no value yields X; 11 selects imm_i unchanged.
- No combinational path from any input to any output.

Decomposition:
- Shared core package holds:
  - WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10, WB_IMM=2'b11.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- One natural sub-module: load_extend (inputs funct3, addr_lo, raw word; output formatted word; purely combinational). Reusable by a future misaligned-load unit.

Test Plan:
- Reset then load, end to end:
  - Hold rst_n=1 for 2 edges → all outputs 0.
  - Release, then valid=1, RegWrite=1, rd=5, wb_sel=00, alu=0x0000_1234.
  - Next edge → RegWrite_o=1, rd_o=5, wdata_o=0x0000_1234.
- Load extension: mem_rdata=0x80F0_7F81, wb_sel=01.
  - LB off 0 → 0xFFFF_FF81.
  - LBU off 3 → 0x0000_0080.
  - LH off 2 → 0xFFFF_80F0.
  - LHU off 0 → 0x0000_7F81.
  - LW → 0x80F0_7F81.
- x0 suppression: rd=0, RegWrite=1, valid=1 → RegWrite_o=0, rd_o=0.
- Stall hold, then flush priority:
  - Load rd=7 / wdata=0xDEAD_BEEF, then stall_i=1 for 3 edges with different inputs → outputs unchanged.
  - Then stall_i=1 and flush_i=1 together → valid_o=0, RegWrite_o=0, rd_o=0, wdata_o=0.
- Source select: pc_plus4=0x0000_0104, imm=0x1234_5000.
  - wb_sel=10 → wdata_o=0x0000_0104.
  - wb_sel=11 → wdata_o=0x1234_5000.
- Mid-operation reset: back-to-back valid writes to rd=3 and rd=4, with rst_n=1 on the second edge → RegWrite_o=0 and rd_o=0; the write to rd=4 is never seen.
